// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit.
//   hz_state_e : hazard FSM state encoding (run, multicycle freeze, memory wait).
//   hz_ctrl_t  : pipeline control vector {pc_enable, if_id_enable, id_ex_enable,
//                id_ex_bubble, if_id_flush} and the fixed responses built from it.
//   load_use_hazard() : load-use detection between the EX load and the ID reader.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMulti   = 2'd1,
        StMemWait = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_enable;
        logic if_id_enable;
        logic id_ex_enable;
        logic id_ex_bubble;
        logic if_id_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CtrlNormal = '{pc_enable: 1'b1, if_id_enable: 1'b1, id_ex_enable: 1'b1,
                                        id_ex_bubble: 1'b0, if_id_flush: 1'b0};

    // Whole pipeline holds; nothing is squashed so no work is lost.
    localparam hz_ctrl_t CtrlFreeze = '{pc_enable: 1'b0, if_id_enable: 1'b0, id_ex_enable: 1'b0,
                                        id_ex_bubble: 1'b0, if_id_flush: 1'b0};

    // Wrong-path instructions in IF/ID and ID/EX are both replaced by NOPs.
    localparam hz_ctrl_t CtrlBranch = '{pc_enable: 1'b1, if_id_enable: 1'b1, id_ex_enable: 1'b1,
                                        id_ex_bubble: 1'b1, if_id_flush: 1'b1};

    // NOP control vector into ID/EX while the consumer waits in ID for the load.
    localparam hz_ctrl_t CtrlNop = '{pc_enable: 1'b0, if_id_enable: 1'b0, id_ex_enable: 1'b1,
                                     id_ex_bubble: 1'b1, if_id_flush: 1'b0};

    function automatic logic load_use_hazard(input logic       mem_read,
                                             input logic [4:0] rd,
                                             input logic [4:0] rs1,
                                             input logic [4:0] rs2,
                                             input logic       rs1_used,
                                             input logic       rs2_used);
        // x0 is hardwired to zero, so a load targeting it never creates a dependency.
        return mem_read && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset (sync, active-low) ; clear : zero the count next cycle (wins over inc)
//   inc : add one unless already all-ones ; count : current value
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: freezes on memory waits and multicycle EX ops, flushes on
// taken branches, and inserts a bubble on load-use dependencies.
//   clk, reset (sync, active-low)
//   id_ex_mem_read, id_ex_rd           : load in EX and its destination
//   if_id_rs1/rs2, rs1_used/rs2_used   : sources read by the instruction in ID
//   branch_taken                       : EX redirects fetch this cycle
//   mc_start, mc_latency               : multicycle EX op start and freeze length
//   mem_busy                           : data memory stall request
//   pc_enable, if_id_enable, id_ex_enable, id_ex_bubble, if_id_flush : pipeline control
//   stall_count                        : saturating count of cycles with pc_enable=0
//   timeout_err                        : sticky, set when mem_busy persists MEM_TIMEOUT cycles
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_ex_mem_read,
    input  logic [4:0]             id_ex_rd,
    input  logic [4:0]             if_id_rs1,
    input  logic [4:0]             if_id_rs2,
    input  logic                   rs1_used,
    input  logic                   rs2_used,
    input  logic                   branch_taken,
    input  logic                   mc_start,
    input  logic [5:0]             mc_latency,
    input  logic                   mem_busy,
    output logic                   pc_enable,
    output logic                   if_id_enable,
    output logic                   id_ex_enable,
    output logic                   id_ex_bubble,
    output logic                   if_id_flush,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   timeout_err
);

    hz_state_e  state_q, state_d;
    logic [5:0] mc_cnt_q, mc_cnt_d;
    logic       timeout_q, timeout_d;
    logic [7:0] wait_cnt;
    logic       mc_accept;
    logic       freeze;
    logic       load_use;
    hz_ctrl_t   ctrl;

    // A new multicycle op is only taken outside MULTI; a zero length is a no-op.
    assign mc_accept = (state_q != StMulti) && mc_start && (mc_latency != 6'd0);
    assign freeze    = mem_busy || (state_q == StMulti) || mc_accept;
    assign load_use  = load_use_hazard(id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
                                       rs1_used, rs2_used);

    always_comb begin
        if (freeze) begin
            ctrl = CtrlFreeze;
        end else if (branch_taken) begin
            ctrl = CtrlBranch;
        end else if (load_use) begin
            ctrl = CtrlNop;
        end else begin
            ctrl = CtrlNormal;
        end
    end

    assign pc_enable    = ctrl.pc_enable;
    assign if_id_enable = ctrl.if_id_enable;
    assign id_ex_enable = ctrl.id_ex_enable;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign if_id_flush  = ctrl.if_id_flush;

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        unique case (state_q)
            StMulti: begin
                // Counts down even while memory is busy; the freeze covers both.
                mc_cnt_d = mc_cnt_q - 6'd1;
                if (mc_cnt_q == 6'd1) begin
                    state_d = mem_busy ? StMemWait : StRun;
                end
            end
            StRun, StMemWait: begin
                if (mc_accept && (mc_latency != 6'd1)) begin
                    // Start cycle is the first of N frozen cycles.
                    state_d  = StMulti;
                    mc_cnt_d = mc_latency - 6'd1;
                end else begin
                    state_d = mem_busy ? StMemWait : StRun;
                end
            end
            default: begin
                state_d  = StRun;
                mc_cnt_d = 6'd0;
            end
        endcase
    end

    // Sticky flag sets at the edge where wait_cnt becomes MEM_TIMEOUT.
    assign timeout_d = timeout_q || (mem_busy && (wait_cnt == 8'(MEM_TIMEOUT - 1)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StRun;
            mc_cnt_q  <= 6'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_cnt_q  <= mc_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;

    sat_counter #(
        .Width (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (~ctrl.pc_enable),
        .count (stall_count)
    );

    sat_counter #(
        .Width (8)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (~mem_busy),
        .inc   (mem_busy),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam int unsigned StallW  = 16;
    localparam int unsigned Timeout = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_ex_mem_read;
    logic [4:0]        id_ex_rd, if_id_rs1, if_id_rs2;
    logic              rs1_used, rs2_used, branch_taken, mc_start, mem_busy;
    logic [5:0]        mc_latency;
    logic              pc_enable, if_id_enable, id_ex_enable, id_ex_bubble, if_id_flush;
    logic [StallW-1:0] stall_count;
    logic              timeout_err;

    hazard_unit #(
        .STALL_CNT_W (StallW),
        .MEM_TIMEOUT (Timeout)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .rs1_used       (rs1_used),
        .rs2_used       (rs2_used),
        .branch_taken   (branch_taken),
        .mc_start       (mc_start),
        .mc_latency     (mc_latency),
        .mem_busy       (mem_busy),
        .pc_enable      (pc_enable),
        .if_id_enable   (if_id_enable),
        .id_ex_enable   (id_ex_enable),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .stall_count    (stall_count),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    // exp = {pc_enable, if_id_enable, id_ex_enable, id_ex_bubble, if_id_flush}
    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       mcs;
        logic [5:0] lat;
        logic       busy;
        logic [4:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [4:0]        ctrl;
        logic [StallW-1:0] stall;
        logic              to;
        string             name;
    } exp_t;

    localparam logic [4:0] Normal  = 5'b11100;
    localparam logic [4:0] Freeze  = 5'b00000;
    localparam logic [4:0] Branch  = 5'b11111;
    localparam logic [4:0] LoadUse = 5'b00110;

    exp_t              sbq[$];
    int                checks = 0;
    int                errors = 0;
    logic [StallW-1:0] model_stall = '0;
    int                model_wait  = 0;
    logic              model_to    = 1'b0;

    function automatic vec_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic br, input logic mcs, input logic [5:0] lat,
                                input logic busy, input logic [4:0] exp, input string name);
        vec_t v;
        v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.br = br; v.mcs = mcs; v.lat = lat; v.busy = busy; v.exp = exp; v.name = name;
        return v;
    endfunction

    function automatic vec_t idle(input logic busy, input logic [4:0] exp, input string name);
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, busy, exp, name);
    endfunction

    // Drive one cycle at posedge+1, check at the following negedge, return at posedge+1.
    task automatic step(input vec_t v);
        exp_t       e;
        exp_t       d;
        logic [4:0] act;
        id_ex_mem_read = v.mr;  id_ex_rd = v.rd;  if_id_rs1 = v.rs1;  if_id_rs2 = v.rs2;
        rs1_used = v.u1;  rs2_used = v.u2;  branch_taken = v.br;
        mc_start = v.mcs;  mc_latency = v.lat;  mem_busy = v.busy;
        e.ctrl = v.exp; e.stall = model_stall; e.to = model_to; e.name = v.name;
        sbq.push_back(e);
        @(negedge clk);
        d   = sbq.pop_front();
        act = {pc_enable, if_id_enable, id_ex_enable, id_ex_bubble, if_id_flush};
        checks++;
        if (act !== d.ctrl) begin
            errors++;
            $display("FAIL %s ctrl: got %b want %b", d.name, act, d.ctrl);
        end
        checks++;
        if (stall_count !== d.stall) begin
            errors++;
            $display("FAIL %s stall_count: got %0d want %0d", d.name, stall_count, d.stall);
        end
        checks++;
        if (timeout_err !== d.to) begin
            errors++;
            $display("FAIL %s timeout_err: got %b want %b", d.name, timeout_err, d.to);
        end
        // Reference models advance with this cycle's expected behaviour.
        if (!v.exp[4] && model_stall != '1) model_stall = model_stall + 1'b1;
        if (v.busy) begin
            model_wait = (model_wait == 255) ? 255 : model_wait + 1;
            if (model_wait == Timeout) model_to = 1'b1;
        end else begin
            model_wait = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    vec_t tbl[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(0, 5, 5, 0, 1, 0, 0, 0, 0, 0, Normal,  "no_load");
        tbl[1]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, LoadUse, "load_use_rs1");
        tbl[2]  = mk(1, 7, 3, 7, 0, 1, 0, 0, 0, 0, LoadUse, "load_use_rs2");
        tbl[3]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, Normal,  "rd_zero");
        tbl[4]  = mk(1, 5, 5, 5, 0, 0, 0, 0, 0, 0, Normal,  "regs_unused");
        tbl[5]  = mk(1, 5, 5, 0, 1, 0, 1, 0, 0, 0, Branch,  "branch_over_load_use");
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, Branch,  "branch_only");
        tbl[7]  = mk(1, 5, 5, 0, 1, 0, 1, 0, 0, 1, Freeze,  "busy_over_all");
        tbl[8]  = mk(1, 9, 9, 0, 1, 0, 0, 1, 0, 0, LoadUse, "mc_lat0_ignored");
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, Freeze,  "mc_lat1_freeze");
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Normal,  "after_lat1");
        tbl[11] = mk(1, 5, 6, 4, 1, 1, 0, 0, 0, 0, Normal,  "no_reg_match");

        id_ex_mem_read = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
        rs1_used = 0; rs2_used = 0; branch_taken = 0; mc_start = 0; mc_latency = 0;
        mem_busy = 0; reset = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;

        step(idle(1'b0, Normal, "reset_state"));

        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Single load-use stall, then normal flow; stall_count grows by exactly one.
        step(mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, LoadUse, "seq_lu_stall"));
        step(idle(1'b0, Normal, "seq_lu_release"));

        // Three-cycle multicycle op; a second mc_start inside MULTI must be ignored.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, Freeze, "mc3_c1"));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, Freeze, "mc3_c2_restart_ignored"));
        step(idle(1'b0, Freeze, "mc3_c3"));
        step(idle(1'b0, Normal, "mc3_done"));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, Normal, "mc_lat0"));

        // Multicycle op ending while memory is busy carries on as a memory wait.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, Freeze, "mc2_c1"));
        step(idle(1'b1, Freeze, "mc2_c2_busy"));
        step(idle(1'b0, Normal, "mc2_mem_released"));

        // Memory timeout: flag rises at the 255th consecutive busy edge and sticks.
        for (int i = 1; i <= 255; i++) begin
            step(idle(1'b1, Freeze, "mem_busy_hold"));
            if (i == 254) check_bit("timeout_before_255", timeout_err, 1'b0);
            if (i == 255) check_bit("timeout_at_255", timeout_err, 1'b1);
        end
        step(idle(1'b0, Normal, "timeout_sticky"));
        step(idle(1'b0, Normal, "timeout_sticky2"));

        // Reset while MULTI holds mc_cnt=4 abandons the op.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, Freeze, "mc5_c1"));
        reset = 0;
        @(posedge clk);
        #1 reset = 1;
        model_stall = '0; model_wait = 0; model_to = 1'b0;
        step(idle(1'b0, Normal, "post_reset_run"));
        step(idle(1'b0, Normal, "post_reset_run2"));
        step(mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, LoadUse, "post_reset_lu"));
        step(idle(1'b0, Normal, "post_reset_final"));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter STALL_CNT_W, default 16: width of the saturating stall-cycle counter.
REQ-002 Parameter MEM_TIMEOUT, default 255: consecutive mem_busy cycles that set timeout_err (1..255).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset is synchronous and active-low (0 = reset, sampled on posedge clk).
REQ-005 id_ex_mem_read  in  1  instruction currently in EX is a load (driven from ID/EX mem_read_out).
REQ-006 id_ex_rd  in  5  destination register of the instruction in EX.
REQ-007 if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
REQ-008 rs1_used, rs2_used  in  1 each  instruction in ID reads rs1 / rs2.
REQ-009 branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-010 mc_start  in  1  multicycle EX operation begins this cycle; mc_latency  in  6  its total freeze length.
REQ-011 mem_busy  in  1  data memory cannot accept or complete an access this cycle.
REQ-012 pc_enable, if_id_enable, id_ex_enable  out  1 each  write enables for PC, IF/ID and ID/EX.
REQ-013 id_ex_bubble  out  1  zeroes all control inputs into ID/EX, inserting a NOP.
REQ-014 if_id_flush  out  1  clears IF/ID to a NOP.
REQ-015 stall_count  out  STALL_CNT_W  saturating count of cycles with pc_enable=0.
REQ-016 timeout_err  out  1  sticky memory-wait timeout flag.

Function
REQ-017 FSM states: RUN, MULTI, MEM_WAIT; enables, bubble and flush are combinational from state and current inputs, all in the same cycle.
REQ-018 Freeze condition: mem_busy, or state MULTI, or (state RUN/MEM_WAIT and mc_start and mc_latency!=0).
REQ-019 Freeze response: pc_enable=if_id_enable=id_ex_enable=0, id_ex_bubble=0, if_id_flush=0.
REQ-020 Branch response, when not frozen and branch_taken=1: all enables 1, if_id_flush=1, id_ex_bubble=1.
REQ-021 Load-use hazard: id_ex_mem_read and id_ex_rd!=0 and ((rs1_used and if_id_rs1==id_ex_rd) or (rs2_used and if_id_rs2==id_ex_rd)).
REQ-022 Load-use response, when not frozen and no branch: pc_enable=0, if_id_enable=0, id_ex_enable=1, id_ex_bubble=1, if_id_flush=0.
REQ-023 Otherwise: all enables 1, bubble 0, flush 0.
REQ-024 Priority: freeze > branch_taken > load-use > normal.
REQ-025 mc_start with mc_latency=N>=1 freezes exactly N consecutive cycles including the start cycle; N=0 ignores mc_start.
REQ-026 On accepted mc_start: N=1 -> next state RUN (or MEM_WAIT if mem_busy); N>=2 -> MULTI with mc_cnt<=N-1.
REQ-027 In MULTI, mc_cnt decrements every cycle regardless of mem_busy; at mc_cnt==1 next state is MEM_WAIT if mem_busy else RUN.
REQ-028 mc_start while in MULTI is ignored.
REQ-029 In RUN, mem_busy=1 (and no accepted mc_start) -> MEM_WAIT; in MEM_WAIT, mem_busy=0 -> RUN, or MULTI per REQ-026.
REQ-030 wait_cnt (8 bits) increments each cycle mem_busy=1, clears when mem_busy=0, saturates at 255.
REQ-031 timeout_err sets on the cycle wait_cnt reaches MEM_TIMEOUT and holds until reset.
REQ-032 stall_count increments each cycle pc_enable=0 and saturates at all-ones.

Reset
REQ-033 reset=0 at posedge clk: state RUN, mc_cnt=0, wait_cnt=0, stall_count=0, timeout_err=0.
REQ-034 Reset mid-MULTI or mid-MEM_WAIT abandons the operation; the first cycle after reset release evaluates as RUN.

Structure
REQ-035 The FSM state encoding and the NOP control-vector constant belong in the shared pipeline package.
REQ-036 Single flat module; the saturating counter is a natural sub-module, sat_counter, used for stall_count and wait_cnt.

Verification
REQ-037 EX: load to x5; ID: rs1=x5, rs1_used=1 -> one cycle pc_enable=0, if_id_enable=0, id_ex_bubble=1; next cycle normal; stall_count=1.
REQ-038 Same as REQ-037 with id_ex_rd=0 -> no stall.
REQ-039 branch_taken=1 together with a load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_enable=1.
REQ-040 mc_start with mc_latency=3 -> exactly 3 full-freeze cycles, then RUN; mc_latency=0 -> no freeze.
REQ-041 mem_busy held 255 cycles with MEM_TIMEOUT=255 -> timeout_err rises on the 255th cycle and stays 1 after mem_busy drops.
REQ-042 reset=0 during MULTI with mc_cnt=4 -> next cycle state RUN, all enables 1, counters 0.
